// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1, then per-round rotate + PC-2, packing 16 round keys into a 768-bit bus.
// Latency: start edge -> 16/KEYS_PER_CYCLE RUN cycles -> one DONE cycle with done=1 and new round_keys.
// No backpressure: start is only sampled in IDLE; a start while busy is dropped, not queued.
module des_key_schedule #(
  parameter int KEYS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [1:64]  key,
  output logic         busy,
  output logic         done,
  output logic [1:768] round_keys
);

  // Only divisors of 16 give a whole number of RUN cycles.
  if (!(KEYS_PER_CYCLE == 1 || KEYS_PER_CYCLE == 2 || KEYS_PER_CYCLE == 4 ||
        KEYS_PER_CYCLE == 8 || KEYS_PER_CYCLE == 16)) begin : g_bad_kpc
    $error("des_key_schedule: KEYS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // PC-1: output bit j+1 takes key bit PC1[j] (FIPS numbering, parity bits never referenced).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: round-key bit j+1 takes C||D bit PC2[j].
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1_f(input logic [1:64] k);
    logic [1:56] r;
    for (int j = 0; j < 56; j++) r[j+1] = k[PC1[j]];
    return r;
  endfunction

  function automatic logic [1:48] pc2_f(input logic [1:56] cd);
    logic [1:48] r;
    for (int j = 0; j < 48; j++) r[j+1] = cd[PC2[j]];
    return r;
  endfunction

  // Rotate C and D halves independently toward bit 1 (the MSB) by one or two places.
  function automatic logic [1:56] rot_f(input logic [1:56] cd, input logic two);
    logic [1:28] c;
    logic [1:28] d;
    c = cd[1:28];
    d = cd[29:56];
    if (two) begin
      c = {c[3:28], c[1:2]};
      d = {d[3:28], d[1:2]};
    end else begin
      c = {c[2:28], c[1]};
      d = {d[2:28], d[1]};
    end
    return {c, d};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:56]  cd_q, cd_d;
  logic         dec_q, dec_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [1:768] wbuf_q, wbuf_d;
  logic [1:768] rk_q, rk_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Chaining temporaries for the unrolled rounds within one RUN cycle.
  logic [1:56]  cd_w;
  logic [4:0]   rnd_n;
  logic [4:0]   slot_n;
  logic         two_n;

  // Next-state, key rotation chain and working-buffer writes.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    rk_d    = rk_q;
    cd_w    = cd_q;
    rnd_n   = 5'd0;
    slot_n  = 5'd1;
    two_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cd_d    = pc1_f(key);
          dec_d   = decrypt;
          cnt_d   = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < KEYS_PER_CYCLE; j++) begin
          rnd_n  = cnt_q + 5'(j) + 5'd1;
          two_n  = !(rnd_n == 5'd1 || rnd_n == 5'd2 || rnd_n == 5'd9 || rnd_n == 5'd16);
          cd_w   = rot_f(cd_w, two_n);
          slot_n = dec_q ? (5'd17 - rnd_n) : rnd_n;
          wbuf_d[(int'(slot_n) - 1) * 48 + 1 +: 48] = pc2_f(cd_w);
        end
        cd_d  = cd_w;
        cnt_d = cnt_q + 5'(KEYS_PER_CYCLE);
        if (cnt_d == 5'd16) begin
          // Publish the finished set, including this cycle's writes, on entry to DONE.
          rk_d    = wbuf_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
      rk_q    <= rk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign round_keys = rk_q;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key schedule generating all sixteen 48-bit round keys from a 64-bit DES key.
- Packs the keys into the 768-bit bus consumed directly by the round_keys input of des_encryption_unrollfull.
- Supports encrypt or decrypt key order.
- Double-buffered: the downstream encryptor keeps using the previous key set while a new one is computed.

Parameters:
- KEYS_PER_CYCLE, 1: round keys produced per RUN cycle. Legal values are 1, 2, 4, 8, 16. Any other value fails elaboration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request new schedule; sampled only in IDLE.
- decrypt  input  1  key order select, sampled with start. 0 = K1 first, 1 = K16 first.
- key  input  [1:64]  DES key, FIPS bit numbering; bit 1 is MSB. Sampled with start. Parity bits 8, 16, …, 64 are ignored.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when round_keys has just been updated.
- round_keys  output  [1:768]  slot s (s = 1..16) occupies bits [(s-1)*48+1 : s*48]. Slot 1 holds the key for round 1.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, round_keys=0, internal C/D/working buffer/counter=0. Reset mid-RUN aborts the schedule; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load C‖D = PC-1(key) (28+28 bits).
  - Latch decrypt; clear round counter i to 0; go to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle processes KEYS_PER_CYCLE consecutive rounds r = i+1 … i+KEYS_PER_CYCLE, chained combinationally:
  - Rotate C and D left by 1 for r ∈ {1, 2, 9, 16}; otherwise by 2.
  - K_r = PC-2(C‖D) after rotation.
  - Write K_r into working-buffer slot r if decrypt=0, or slot 17-r if decrypt=1.
  - i += KEYS_PER_CYCLE.
  - After round 16 is written, go to DONE. Total rotation is 28, so C/D return to their PC-1 values.
- DONE (one cycle):
  - round_keys <= working buffer, registered on entry to DONE.
  - done=1 for exactly this cycle; return to IDLE.
- Latency: start sampled at edge 0 → RUN occupies 16/KEYS_PER_CYCLE cycles → round_keys valid and done=1 in the following cycle.
  - KEYS_PER_CYCLE=1: done high in cycle 17 after the start edge.
  - KEYS_PER_CYCLE=16: done high in cycle 2.
- round_keys changes only on entry to DONE (or reset). It is stable in every other cycle, including throughout RUN.
- start while busy=1 (RUN or DONE) is ignored and not queued. The next start is accepted in the first IDLE cycle after DONE.
- Changes on key/decrypt after start is sampled have no effect on the schedule in flight.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- KEYS_PER_CYCLE=1, key=64'h133457799BBCDFF1, decrypt=0, start one cycle:
  - done in cycle 17 after the start edge.
  - slot1=48'h1B02EFFC7072, slot2=48'h79AED9DBC9E5, slot16=48'hCB3D8B0E17F5.
  - busy high for cycles 1..17.
- Same key, decrypt=1: slot1=48'hCB3D8B0E17F5, slot15=48'h79AED9DBC9E5, slot16=48'h1B02EFFC7072.
- key=64'h0101010101010101 → all 16 slots 48'h0. key=64'hFEFEFEFEFEFEFEFE → all slots 48'hFFFFFFFFFFFF. Checks that parity bits are dropped.
- Double-buffer and ignored start:
  - Complete one schedule with key 133457799BBCDFF1.
  - Start a second with key 0101010101010101; pulse start again during RUN with a different key.
  - round_keys must hold the first result until the second done; exactly one done pulse follows.
  - The result must match the zero-key vector.
- Reset mid-operation: assert rst at RUN cycle 8 → busy=0, done=0, round_keys=0 immediately (async). No done afterwards; a new start then completes normally.
- Parameter sweep KEYS_PER_CYCLE ∈ {2, 4, 16} with the vector from the first scenario → identical round_keys, done at cycle 16/KEYS_PER_CYCLE+1. End-to-end: feed des_encryption_unrollfull the produced round_keys with message 64'h0123456789ABCDEF → result 64'h85E813540F0AB405.
